// File: rtl/inject_queue_pkg.sv
// Shared types and defaults for the ring-node injection queue.
// Flit layout: STEER_W bits wide, with the MSB used as the flit-valid marker.
package inject_queue_pkg;

    // Flit geometry shared with the ring datapath.
    localparam int STEER_W = 16;
    localparam int VALID_F = STEER_W - 1;

    // Queue defaults.
    localparam int INJQ_DEPTH      = 4;
    localparam int INJQ_STARVE_LIM = 16;
    localparam int INJQ_CNT_W      = 8;

    typedef logic [STEER_W-1:0] flit_t;

    // Local flits arrive with an unreliable valid bit; the queue owns it.
    function automatic flit_t mark_valid(input flit_t f);
        flit_t r;
        r          = f;
        r[VALID_F] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/inject_queue_fifo.sv
// One per-channel injection FIFO.
// Holds storage, pointers, occupancy and the head wait counter that drives the
// starvation flag. There is no bypass in either direction: a push is visible on
// head_o one cycle later, and a push into a full FIFO is dropped even if a pop
// happens in the same cycle.
module inject_fifo
    import inject_queue_pkg::*;
#(
    parameter int DEPTH      = INJQ_DEPTH,
    parameter int STARVE_LIM = INJQ_STARVE_LIM,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = INJQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  flit_t            data_i,
    input  logic             pop_i,
    output flit_t            head_o,
    output logic [PTR_W:0]   occ_o,
    output logic             full_o,
    output logic             starve_o
);

    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(STARVE_LIM);

    flit_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             starve_q, starve_d;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == OCC_FULL);
    assign do_push = push_i & ~full;
    // A pop on an empty FIFO is ignored so occupancy can never underflow.
    assign do_pop  = pop_i & ~empty;

    // Next-state for pointers, occupancy, wait counter and starvation flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        wait_d   = wait_q;

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // The counter measures how long the current head has gone unserved.
        if (pop_i || empty) begin
            wait_d = '0;
        end else if (wait_q != CNT_LIM) begin
            wait_d = wait_q + 1'b1;
        end

        starve_d = (wait_d == CNT_LIM);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    // Flit storage; contents are only observed while occupancy covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o   = empty ? '0 : mem_q[rd_ptr_q];
    assign occ_o    = occ_q;
    assign full_o   = full;
    assign starve_o = starve_q;

endmodule

// File: rtl/inject_queue.sv
// Local injection buffer of a ring node.
// Steers local flits into one of two channel FIFOs and presents each FIFO head
// to the injector; ack0/ack1 pop the corresponding head.
module inject_queue
    import inject_queue_pkg::*;
#(
    parameter int DEPTH      = INJQ_DEPTH,
    parameter int STARVE_LIM = INJQ_STARVE_LIM,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = INJQ_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STEER_W-1:0] in_flit,
    input  logic               in_ch,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [STEER_W-1:0] c_in0,
    output logic [STEER_W-1:0] c_in1,
    input  logic               ack0,
    input  logic               ack1,
    output logic [PTR_W:0]     occ0,
    output logic [PTR_W:0]     occ1,
    output logic               starve0,
    output logic               starve1
);

    logic  full0, full1;
    logic  push0, push1;
    flit_t flit_in;

    // Handshake: a flit is accepted on a rising edge where in_valid and in_ready
    // are both high; in_ready depends only on the selected channel's full flag
    // (and is held low during reset), never on ack.
    assign in_ready = rst_n & ~(in_ch ? full1 : full0);
    assign push0    = in_valid & in_ready & ~in_ch;
    assign push1    = in_valid & in_ready &  in_ch;
    assign flit_in  = mark_valid(in_flit);

    inject_fifo #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_fifo0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push0),
        .data_i   (flit_in),
        .pop_i    (ack0),
        .head_o   (c_in0),
        .occ_o    (occ0),
        .full_o   (full0),
        .starve_o (starve0)
    );

    inject_fifo #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push1),
        .data_i   (flit_in),
        .pop_i    (ack1),
        .head_o   (c_in1),
        .occ_o    (occ1),
        .full_o   (full1),
        .starve_o (starve1)
    );

endmodule

// File: tb/tb_inject_queue.sv
// Directed bench for inject_queue: FIFO order, full/reject, starvation,
// spurious ack, pointer wrap and asynchronous reset mid-traffic.
module tb_inject_queue;
    import inject_queue_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [STEER_W-1:0] in_flit;
    logic               in_ch;
    logic               in_valid;
    logic               in_ready;
    logic [STEER_W-1:0] c_in0;
    logic [STEER_W-1:0] c_in1;
    logic               ack0;
    logic               ack1;
    logic [2:0]         occ0;
    logic [2:0]         occ1;
    logic               starve0;
    logic               starve1;

    int n_vec = 0;
    int n_err = 0;

    inject_queue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_flit  (in_flit),
        .in_ch    (in_ch),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .c_in0    (c_in0),
        .c_in1    (c_in1),
        .ack0     (ack0),
        .ack1     (ack1),
        .occ0     (occ0),
        .occ1     (occ1),
        .starve0  (starve0),
        .starve1  (starve1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected head value: the queue forces the MSB valid marker.
    function automatic logic [STEER_W-1:0] vf(input logic [STEER_W-1:0] f);
        return f | 16'h8000;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ch, input logic [STEER_W-1:0] f,
                         input logic a0, input logic a1);
        in_valid = v;
        in_ch    = ch;
        in_flit  = f;
        ack0     = a0;
        ack1     = a1;
        #1;
    endtask

    initial begin
        // Reset with a push attempt held active.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0055, 1'b0, 1'b0);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_c_in0",    32'(c_in0),    32'd0);
        check("rst_occ0",     32'(occ0),     32'd0);
        check("rst_starve0",  32'(starve0),  32'd0);
        step();
        step();
        check("rst_no_push", 32'(occ0), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step();

        // Push A,B,C on ch0; ack0 from the second cycle.
        drive(1'b1, 1'b0, 16'h0A0A, 1'b0, 1'b0);
        check("t2_ready",  32'(in_ready), 32'd1);
        check("t2_empty",  32'(c_in0),    32'd0);
        step();
        drive(1'b1, 1'b0, 16'h0B0B, 1'b1, 1'b0);
        check("t2_head_a", 32'(c_in0), 32'(vf(16'h0A0A)));
        check("t2_occ_a",  32'(occ0),  32'd1);
        step();
        drive(1'b1, 1'b0, 16'h0C0C, 1'b1, 1'b0);
        check("t2_head_b", 32'(c_in0), 32'(vf(16'h0B0B)));
        check("t2_occ_b",  32'(occ0),  32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t2_head_c", 32'(c_in0), 32'(vf(16'h0C0C)));
        check("t2_occ_c",  32'(occ0),  32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_drained", 32'(occ0),  32'd0);
        check("t2_zero",    32'(c_in0), 32'd0);

        // Fill ch1, then push while acking at the same edge.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_occ1",       32'(occ1),     32'd4);
        check("t3_head_d0",    32'(c_in1),    32'(vf(16'h0D00)));
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t3_ch0_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b1, 16'h0EEE, 1'b0, 1'b1);
        check("t3_rej_ready", 32'(in_ready), 32'd0);
        step();
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check("t3_occ_after", 32'(occ1),  32'd3);
        check("t3_head_d1",   32'(c_in1), 32'(vf(16'h0D01)));
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
            check("t3_drain", 32'(c_in1), 32'(vf(16'h0D00 + 16'(i))));
            step();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t3_empty", 32'(occ1), 32'd0);

        // Starvation on ch0.
        drive(1'b1, 1'b0, 16'h0123, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t4_start", 32'(starve0), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check("t4_wait", 32'(starve0), (i == 16) ? 32'd1 : 32'd0);
        end
        step();
        check("t4_sat", 32'(starve0), 32'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t4_pre_ack", 32'(starve0), 32'd1);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t4_drop", 32'(starve0), 32'd0);
        check("t4_occ",  32'(occ0),    32'd0);

        // Spurious ack on empty ch1.
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        step();
        check("t5_occ1",  32'(occ1),               32'd0);
        check("t5_valid", 32'(c_in1[STEER_W-1]),   32'd0);
        drive(1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t5_occ_push", 32'(occ1),  32'd1);
        check("t5_head",     32'(c_in1), 32'(vf(16'h0F0F)));
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t5_empty", 32'(occ1), 32'd0);

        // Ten push/pop pairs on ch0 across pointer wrap.
        drive(1'b1, 1'b0, 16'h0A00, 1'b0, 1'b0);
        step();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 1'b0, 16'h0A00 + 16'(i), 1'b1, 1'b0);
            check("t6_head", 32'(c_in0), 32'(vf(16'h0A00 + 16'(i - 1))));
            check("t6_occ",  32'(occ0),  32'd1);
            step();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("t6_last", 32'(c_in0), 32'(vf(16'h0A09)));
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6_empty", 32'(occ0), 32'd0);

        // Async reset in the middle of traffic with starve1 asserted.
        drive(1'b1, 1'b0, 16'h0111, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 16'h0222, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        check("t1_pre_starve1", 32'(starve1), 32'd1);
        check("t1_pre_occ0",    32'(occ0),    32'd1);
        drive(1'b1, 1'b0, 16'h0333, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_c_in0",    32'(c_in0),    32'd0);
        check("t1_c_in1",    32'(c_in1),    32'd0);
        check("t1_occ0",     32'(occ0),     32'd0);
        check("t1_occ1",     32'(occ1),     32'd0);
        check("t1_starve0",  32'(starve0),  32'd0);
        check("t1_starve1",  32'(starve1),  32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h0444, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t1_post_occ0", 32'(occ0),  32'd1);
        check("t1_post_head", 32'(c_in0), 32'(vf(16'h0444)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
